matrix_product_engine: RTL and testbench
========================================

MATRIX_PRODUCT_ENGINE -- requirements
Module: matrix_product_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 8, matrix dimension; legal values 4 or 8.
- DATA_W, 16, signed width of A elements.
- COEF_W, 16, signed width of C elements.
- ACC_W, 32, signed accumulator width.
- OUT_W, 16, result width.
- SHIFT, 8, arithmetic right shift applied to the accumulator before output.
REQ-002 Local constant AW SHALL equal 2*log2(N).
REQ-003 Ports SHALL be, one per line:
- Clock_50  in  1  sole clock; all logic rises on posedge.
- Resetn  in  1  asynchronous active-low reset.
- start  in  1  start request, sampled in S_IDLE.
- mode  in  1  0: R=A*C; 1: R=transpose(C)*A.
- clip_en  in  1  clip result to [0,255].
- Address_A  out  AW  A RAM read address.
- Data_out_A  in  DATA_W  A RAM read data.
- Address_C  out  AW  C RAM read address.
- Data_out_C  in  COEF_W  C RAM read data.
- Address_R  out  AW  R RAM write address.
- Write_en_R  out  1  R RAM write enable.
- Data_in_R  out  OUT_W  R RAM write data.
- busy  out  1  high from start acceptance until finish.
- finish  out  1  one-cycle completion pulse.
REQ-004 Read RAMs SHALL have 1-cycle read latency; all matrices SHALL be stored row-major, with element [r][c] at address r*N+c.

Function
REQ-005 FSM states SHALL be S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE.
REQ-006 In S_IDLE, start=1 SHALL be accepted (cycle 0), mode and clip_en SHALL be latched, busy SHALL rise, and the FSM SHALL go to S_MAC.
REQ-007 The engine SHALL compute elements (i,j) in row-major order: i outer, j inner, 0..N-1.
REQ-008 S_MAC SHALL last N cycles, issuing read index k=0..N-1.
- mode 0: Address_A = i*N+k, Address_C = k*N+j.
- mode 1: Address_A = k*N+j, Address_C = k*N+i.
REQ-009 Each returned product SHALL be accumulated one cycle after its issue cycle; the accumulator SHALL load (not add) the k=0 product.
REQ-010 S_DRAIN (1 cycle) SHALL accumulate the k=N-1 product.
REQ-011 S_WRITE (1 cycle) SHALL drive Write_en_R=1, Address_R=i*N+j, and Data_in_R = result, then go to S_MAC for the next element, or to S_DONE after element (N-1,N-1).
REQ-012 Product SHALL be the signed DATA_W x COEF_W product; the sum SHALL wrap modulo 2^ACC_W with no saturation.
REQ-013 Result SHALL be acc >>> SHIFT (sign-preserving).
- clip_en=1: values <0 give 0, values >255 give 255.
- clip_en=0: result is the low OUT_W bits.
REQ-014 S_DONE SHALL pulse finish=1 for exactly one cycle, drop busy, and return to S_IDLE.
REQ-015 Latency: finish SHALL be high in cycle N*N*(N+2)+1 after acceptance (641 for N=8, 97 for N=4).
REQ-016 Write_en_R SHALL be high exactly N*N cycles per run and never outside S_WRITE.
REQ-017 start SHALL be ignored outside S_IDLE; start held high through S_DONE SHALL begin a new run on the first S_IDLE cycle.
REQ-018 mode and clip_en changes during a run SHALL have no effect.

Reset
REQ-019 On Resetn=0, at any time including mid-run, the FSM SHALL enter S_IDLE immediately, abort the run with no further writes, and drive all outputs, accumulator, and counters to 0.
REQ-020 After Resetn deassertion, the engine SHALL require a new start.

Structure
REQ-021 Package mpe_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-022 Multiply-accumulate SHALL be a sub-module mpe_mac (load/accumulate control, signed operands, ACC_W output); address generation and shift/clip SHALL be in the top level.

Verification
REQ-023 N=8, SHIFT=0, mode 0, clip off, C=identity, A[r][c]=r*8+c -> R equals A; finish in cycle 641; exactly 64 writes.
REQ-024 SHIFT=0, C[k][j]=1 iff j=k+1, A[r][c]=r*8+c:
- mode 0 -> R[i][j]=A[i][j-1] and R[i][0]=0.
- mode 1 -> R[i][j]=A[i-1][j] and R[0][j]=0.
REQ-025 SHIFT=0, C=identity, clip on:
- A all -100 -> R all 0.
- A all 300 -> R all 255.
- Clip off with A all -100 -> R all 0xFF9C.
REQ-026 SHIFT=8, A[0][0]=-1, C[0][0]=1, others 0, clip off -> R[0][0]=0xFFFF and all other R elements 0.
REQ-027 Pulse start at cycles 5 and 300 of a run -> second start ignored; single finish pulse; busy continuous.
REQ-028 Resetn low at cycle 100 -> Write_en_R, busy, and finish all 0 immediately; a subsequent start completes with correct R (N=4 build: finish in cycle 97).

Source files
------------

// File: rtl/mpe_pkg.sv
// Shared types and default sizing for the matrix product engine.
package mpe_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int N_DEF      = 8;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int OUT_W_DEF  = 16;
  localparam int SHIFT_DEF  = 8;

endpackage

// File: rtl/mpe_mac.sv
// Signed multiply-accumulate; control is delayed one cycle internally to line up
// with the one-cycle read latency of the operand RAMs.
module mpe_mac
  import mpe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              issue,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] c,
  output logic [ACC_W-1:0]  acc
);

  localparam int PW = DATA_W + COEF_W;

  logic             en_q, en_d;
  logic             load_q, load_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;

  // Product of the operands returned for the previous issue cycle; sum wraps.
  always_comb begin
    prod_s     = PW'($signed(a)) * PW'($signed(c));
    prod_ext_s = ACC_W'(prod_s);
    en_d       = issue;
    load_d     = first;
    acc_d      = acc_q;
    if (srst) begin
      en_d   = 1'b0;
      load_d = 1'b0;
      acc_d  = '0;
    end else if (en_q) begin
      if (load_q) begin
        acc_d = prod_ext_s;
      end else begin
        acc_d = acc_q + prod_ext_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and delayed control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      load_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      en_q   <= en_d;
      load_q <= load_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matrix_product_engine.sv
// Computes R = A*C (mode 0) or R = transpose(C)*A (mode 1) over row-major RAMs,
// one element at a time, with arithmetic shift and optional [0,255] clipping.
module matrix_product_engine
  import mpe_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  localparam int LW    = $clog2(N),
  localparam int AW    = 2 * LW
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              start,
  input  logic              mode,
  input  logic              clip_en,
  output logic [AW-1:0]     Address_A,
  input  logic [DATA_W-1:0] Data_out_A,
  output logic [AW-1:0]     Address_C,
  input  logic [COEF_W-1:0] Data_out_C,
  output logic [AW-1:0]     Address_R,
  output logic              Write_en_R,
  output logic [OUT_W-1:0]  Data_in_R,
  output logic              busy,
  output logic              finish
);

  localparam logic [LW-1:0]         IDX_LAST = LW'(N - 1);
  localparam logic signed [ACC_W-1:0] CLIP_HI = ACC_W'(32'sd255);

  state_e        state_q, state_d;
  logic [LW-1:0] i_q, i_d;
  logic [LW-1:0] j_q, j_d;
  logic [LW-1:0] k_q, k_d;
  logic          mode_q, mode_d;
  logic          clip_q, clip_d;

  logic                    issue_s, first_s, mac_clr_s;
  logic [ACC_W-1:0]        acc_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic [OUT_W-1:0]        result_s;

  mpe_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (Clock_50),
    .rst_n (Resetn),
    .srst  (mac_clr_s),
    .issue (issue_s),
    .first (first_s),
    .a     (Data_out_A),
    .c     (Data_out_C),
    .acc   (acc_s)
  );

  // State, element counters and latched run configuration.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      clip_q  <= clip_d;
    end
  end

  // Next-state sequencing: N issue cycles, one drain, one write per element.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_MAC;
        else       state_d = S_IDLE;
      end
      S_MAC: begin
        if (k_q == IDX_LAST) state_d = S_DRAIN;
        else                 state_d = S_MAC;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) state_d = S_DONE;
        else                                        state_d = S_MAC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index counters walk k inside an element, then j, then i.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    mode_d = mode_q;
    clip_d = clip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          clip_d = clip_en;
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
        end else begin
          mode_d = mode_q;
          clip_d = clip_q;
        end
      end
      S_MAC: begin
        if (k_q == IDX_LAST) k_d = '0;
        else                 k_d = k_q + LW'(1);
      end
      S_WRITE: begin
        if (j_q == IDX_LAST) begin
          j_d = '0;
          if (i_q == IDX_LAST) i_d = '0;
          else                 i_d = i_q + LW'(1);
        end else begin
          j_d = j_q + LW'(1);
        end
      end
      default: begin
        k_d = k_q;
      end
    endcase
  end

  // Shift then either saturate to a byte or keep the low OUT_W bits.
  always_comb begin
    shifted_s = $signed(acc_s) >>> SHIFT;
    if (clip_q) begin
      if (shifted_s[ACC_W-1])      result_s = '0;
      else if (shifted_s > CLIP_HI) result_s = OUT_W'(32'd255);
      else                         result_s = shifted_s[OUT_W-1:0];
    end else begin
      result_s = shifted_s[OUT_W-1:0];
    end
  end

  // Output decode; row-major addresses are plain index concatenations.
  always_comb begin
    Address_A  = '0;
    Address_C  = '0;
    Address_R  = '0;
    Write_en_R = 1'b0;
    Data_in_R  = '0;
    busy       = 1'b0;
    finish     = 1'b0;
    issue_s    = 1'b0;
    first_s    = 1'b0;
    mac_clr_s  = 1'b0;
    case (state_q)
      S_IDLE: mac_clr_s = 1'b1;
      S_MAC: begin
        busy    = 1'b1;
        issue_s = 1'b1;
        first_s = (k_q == '0);
        if (mode_q) begin
          Address_A = {k_q, j_q};
          Address_C = {k_q, i_q};
        end else begin
          Address_A = {i_q, k_q};
          Address_C = {k_q, j_q};
        end
      end
      S_DRAIN: busy = 1'b1;
      S_WRITE: begin
        busy       = 1'b1;
        Write_en_R = 1'b1;
        Address_R  = {i_q, j_q};
        Data_in_R  = result_s;
      end
      S_DONE:  finish = 1'b1;
      default: mac_clr_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_matrix_product_engine.sv
// Scoreboard bench: an N=8/SHIFT=0 engine and an N=4/SHIFT=8 engine share clock
// and reset; expected writes are queued at start and popped as writes appear.
module tb_matrix_product_engine;

  logic clk, rst_n, mode_s, clip_s, start8, start4;

  logic [5:0] aa8, ac8, ar8;
  logic [15:0] da8, dc8, din8;
  logic we8, busy8, fin8;
  logic [3:0] aa4, ac4, ar4;
  logic [15:0] da4, dc4, din4;
  logic we4, busy4, fin4;

  logic signed [15:0] a8 [64];
  logic signed [15:0] c8 [64];
  logic signed [15:0] a4 [16];
  logic signed [15:0] c4 [16];
  logic [15:0] r8 [64];
  logic [15:0] r4 [16];
  logic [31:0] q8 [$];
  logic [31:0] q4 [$];

  int n_tests = 0;
  int n_fail  = 0;
  int wr8 = 0;
  int wr4 = 0;

  matrix_product_engine #(.N(8), .DATA_W(16), .COEF_W(16), .ACC_W(32), .OUT_W(16), .SHIFT(0)) u_dut8 (
    .Clock_50(clk), .Resetn(rst_n), .start(start8), .mode(mode_s), .clip_en(clip_s),
    .Address_A(aa8), .Data_out_A(da8), .Address_C(ac8), .Data_out_C(dc8),
    .Address_R(ar8), .Write_en_R(we8), .Data_in_R(din8), .busy(busy8), .finish(fin8));

  matrix_product_engine #(.N(4), .DATA_W(16), .COEF_W(16), .ACC_W(32), .OUT_W(16), .SHIFT(8)) u_dut4 (
    .Clock_50(clk), .Resetn(rst_n), .start(start4), .mode(mode_s), .clip_en(clip_s),
    .Address_A(aa4), .Data_out_A(da4), .Address_C(ac4), .Data_out_C(dc4),
    .Address_R(ar4), .Write_en_R(we4), .Data_in_R(din4), .busy(busy4), .finish(fin4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    da8 <= a8[aa8];
    dc8 <= c8[ac8];
    da4 <= a4[aa4];
    dc4 <= c4[ac4];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (we8 === 1'b1) begin
      wr8++;
      if (q8.size() == 0) check("wr8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("wr8_addr", 32'(ar8), 32'(e[31:16]));
        check("wr8_data", 32'(din8), 32'(e[15:0]));
      end
      r8[ar8] = din8;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (we4 === 1'b1) begin
      wr4++;
      if (q4.size() == 0) check("wr4_unexpected", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("wr4_addr", 32'(ar4), 32'(e[31:16]));
        check("wr4_data", 32'(din4), 32'(e[15:0]));
      end
      r4[ar4] = din4;
    end
  end

  function automatic logic signed [15:0] get_a(input int sel, input int idx);
    return (sel == 1) ? a4[idx] : a8[idx];
  endfunction

  function automatic logic signed [15:0] get_c(input int sel, input int idx);
    return (sel == 1) ? c4[idx] : c8[idx];
  endfunction

  function automatic logic get_fin(input int sel);
    return (sel == 1) ? fin4 : fin8;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy4 : busy8;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start4 = v;
    else          start8 = v;
  endtask

  // Reference: plain matrix product, 32-bit wrap, arithmetic shift, clip.
  function automatic void push_exp(input int sel, input logic m, input logic cl);
    int n, sh;
    logic signed [31:0] acc, sv;
    logic [15:0] o;
    n  = (sel == 1) ? 4 : 8;
    sh = (sel == 1) ? 8 : 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 32'sd0;
        for (int k = 0; k < n; k++) begin
          if (!m) acc = acc + get_a(sel, i*n+k) * get_c(sel, k*n+j);
          else    acc = acc + get_c(sel, k*n+i) * get_a(sel, k*n+j);
        end
        sv = acc >>> sh;
        if (cl) begin
          if (sv < 0)        o = 16'd0;
          else if (sv > 255) o = 16'd255;
          else               o = sv[15:0];
        end else begin
          o = sv[15:0];
        end
        if (sel == 1) q4.push_back({16'(i*n+j), o});
        else          q8.push_back({16'(i*n+j), o});
      end
    end
  endfunction

  task automatic run(input int sel, input logic m, input logic cl, input bit extra, input int abort_at);
    int n, c, fin_c, bz_lo, fin_extra, w0;
    n = (sel == 1) ? 4 : 8;
    for (int x = 0; x < 64; x++) r8[x] = 16'hDEAD;
    for (int x = 0; x < 16; x++) r4[x] = 16'hDEAD;
    push_exp(sel, m, cl);
    w0 = (sel == 1) ? wr4 : wr8;
    @(negedge clk);
    mode_s = m;
    clip_s = cl;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    mode_s = ~m;
    clip_s = ~cl;
    c = 1; fin_c = 0; bz_lo = 0;
    while (fin_c == 0 && c < 1500 && (abort_at == 0 || c < abort_at)) begin
      if (get_fin(sel)) fin_c = c;
      else begin
        if (!get_busy(sel)) bz_lo++;
        set_start(sel, extra && (c == 5 || c == 300));
        @(negedge clk);
        c++;
      end
    end
    set_start(sel, 1'b0);
    if (abort_at != 0 && c == abort_at) begin
      rst_n = 1'b0;
      #1;
      check("abort_we", 32'(we8), 32'd0);
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_finish", 32'(fin8), 32'd0);
      check("abort_addr_a", 32'(aa8), 32'd0);
      check("abort_data_r", 32'(din8), 32'd0);
      q8.delete();
      q4.delete();
      w0 = wr8;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_after_reset", 32'(busy8), 32'd0);
      check("no_wr_after_reset", 32'(wr8 - w0), 32'd0);
    end else begin
      check("finish_cycle", 32'(fin_c), 32'(n*n*(n+2)+1));
      check("busy_gap", 32'(bz_lo), 32'd0);
      check("busy_at_finish", 32'(get_busy(sel)), 32'd0);
      fin_extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (get_fin(sel)) fin_extra++;
      end
      check("finish_pulse", 32'(fin_extra), 32'd0);
      check("write_count", 32'(((sel == 1) ? wr4 : wr8) - w0), 32'(n*n));
      check("queue_empty", 32'((sel == 1) ? q4.size() : q8.size()), 32'd0);
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; mode_s = 1'b0; clip_s = 1'b0;
    for (int x = 0; x < 64; x++) begin a8[x] = 16'sd0; c8[x] = 16'sd0; end
    for (int x = 0; x < 16; x++) begin a4[x] = 16'sd0; c4[x] = 16'sd0; end
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_fin8", 32'(fin8), 32'd0);
    check("rst_we8", 32'(we8), 32'd0);
    check("rst_addr_a8", 32'(aa8), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int x = 0; x < 64; x++) begin a8[x] = 16'(x); c8[x] = (x/8 == x%8) ? 16'sd1 : 16'sd0; end
    run(0, 1'b0, 1'b0, 1'b0, 0);
    check("ident_r63", 32'(r8[63]), 32'd63);
    check("ident_r10", 32'(r8[10]), 32'd10);

    for (int x = 0; x < 64; x++) c8[x] = (x%8 == x/8 + 1) ? 16'sd1 : 16'sd0;
    run(0, 1'b0, 1'b0, 1'b0, 0);
    check("shift_m0_r9", 32'(r8[9]), 32'd8);
    check("shift_m0_r8", 32'(r8[8]), 32'd0);
    check("shift_m0_r63", 32'(r8[63]), 32'd62);
    run(0, 1'b1, 1'b0, 1'b0, 0);
    check("shift_m1_r9", 32'(r8[9]), 32'd1);
    check("shift_m1_r3", 32'(r8[3]), 32'd0);
    check("shift_m1_r63", 32'(r8[63]), 32'd55);

    for (int x = 0; x < 64; x++) begin a8[x] = -16'sd100; c8[x] = (x/8 == x%8) ? 16'sd1 : 16'sd0; end
    run(0, 1'b0, 1'b1, 1'b0, 0);
    check("clip_neg_r0", 32'(r8[0]), 32'd0);
    run(0, 1'b0, 1'b0, 1'b0, 0);
    check("noclip_neg_r5", 32'(r8[5]), 32'h0000FF9C);
    for (int x = 0; x < 64; x++) a8[x] = 16'sd300;
    run(0, 1'b0, 1'b1, 1'b0, 0);
    check("clip_pos_r27", 32'(r8[27]), 32'd255);

    for (int x = 0; x < 64; x++) begin
      t = int'($urandom_range(1000, 0)) - 500;
      a8[x] = 16'(t);
      t = int'($urandom_range(100, 0)) - 50;
      c8[x] = 16'(t);
    end
    run(0, 1'b1, 1'b0, 1'b1, 0);
    run(0, 1'b0, 1'b0, 1'b0, 100);
    run(0, 1'b0, 1'b1, 1'b0, 0);

    a4[0] = -16'sd1;
    c4[0] = 16'sd1;
    run(1, 1'b0, 1'b0, 1'b0, 0);
    check("n4_neg_r0", 32'(r4[0]), 32'h0000FFFF);
    check("n4_neg_r5", 32'(r4[5]), 32'd0);
    for (int x = 0; x < 16; x++) begin
      t = int'($urandom_range(20000, 0)) - 10000;
      a4[x] = 16'(t);
      t = int'($urandom_range(200, 0)) - 100;
      c4[x] = 16'(t);
    end
    run(1, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
